// File: rtl/cv32e40x_mpu_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40x_mpu_arbiter
//
// Shares the data-side MPU between the LSU (requester 0) and the eXtension
// interface memory port (requester 1).
//   - LSU has fixed priority. An XIF starvation counter forces XIF to win once
//     it has lost STARVE_LIMIT consecutive cycles.
//   - The grant is locked (HOLD states) while a presented request is unaccepted.
//   - A small owner FIFO records who issued each outstanding transaction, so
//     in-order MPU responses are routed back to the right requester.
//   - XIF requests rejected by the MPU (mpu_err_i) get xif_mpu_err_o instead of
//     a response and are not pushed. LSU errored requests are pushed because
//     the MPU answers them later.
//
// Ports
//   clk, rst_n                            clock, async active-low reset
//   lsu_trans_valid_i/ready_o/trans_i     LSU request channel
//   lsu_resp_valid_o/resp_o               LSU response channel
//   xif_trans_valid_i/ready_o/trans_i     XIF request channel
//   xif_resp_valid_o/resp_o               XIF response channel
//   xif_mpu_err_o                         XIF request accepted with MPU error
//   mpu_trans_valid_o/ready_i/trans_o     selected request towards the MPU
//   mpu_err_wait_o                        1 when LSU selected, 0 when XIF selected
//   mpu_err_i                             MPU immediate error for current request
//   mpu_one_txn_pend_n_o                  exactly one outstanding txn next cycle
//   mpu_resp_valid_i/resp_i               in-order MPU response
// -----------------------------------------------------------------------------
module cv32e40x_mpu_arbiter #(
  parameter type         TRANS_TYPE   = logic [31:0],
  parameter type         RESP_TYPE    = logic [31:0],
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst_n,

  input  logic      lsu_trans_valid_i,
  output logic      lsu_trans_ready_o,
  input  TRANS_TYPE lsu_trans_i,
  output logic      lsu_resp_valid_o,
  output RESP_TYPE  lsu_resp_o,

  input  logic      xif_trans_valid_i,
  output logic      xif_trans_ready_o,
  input  TRANS_TYPE xif_trans_i,
  output logic      xif_resp_valid_o,
  output RESP_TYPE  xif_resp_o,
  output logic      xif_mpu_err_o,

  output logic      mpu_trans_valid_o,
  input  logic      mpu_trans_ready_i,
  output TRANS_TYPE mpu_trans_o,
  output logic      mpu_err_wait_o,
  input  logic      mpu_err_i,
  output logic      mpu_one_txn_pend_n_o,
  input  logic      mpu_resp_valid_i,
  input  RESP_TYPE  mpu_resp_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StFree, StHoldLsu, StHoldXif} state_e;

  state_e              r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_nxt;
  logic [StvW-1:0]     r_starve, w_starve_nxt;
  logic [PtrW-1:0]     r_wptr, r_rptr;
  logic [DEPTH-1:0]    r_owner;  // 1 = XIF owns the entry

  logic w_sel_xif, w_sel_valid, w_full, w_empty, w_hs, w_push, w_pop, w_head_xif;

  // Requester selection: locked to the held requester in HOLD states.
  always_comb begin
    w_sel_xif = 1'b0;
    unique case (r_state)
      StHoldLsu: w_sel_xif = 1'b0;
      StHoldXif: w_sel_xif = 1'b1;
      default:   w_sel_xif = xif_trans_valid_i &&
                             (!lsu_trans_valid_i || (r_starve == StvW'(STARVE_LIMIT)));
    endcase
  end

  assign w_sel_valid = w_sel_xif ? xif_trans_valid_i : lsu_trans_valid_i;
  assign w_full      = (r_cnt == CntW'(DEPTH));
  assign w_empty     = (r_cnt == '0);

  assign mpu_trans_valid_o = w_sel_valid && !w_full;
  assign mpu_trans_o       = w_sel_xif ? xif_trans_i : lsu_trans_i;
  assign mpu_err_wait_o    = !w_sel_xif;
  assign lsu_trans_ready_o = !w_sel_xif && mpu_trans_ready_i && !w_full;
  assign xif_trans_ready_o =  w_sel_xif && mpu_trans_ready_i && !w_full;

  assign w_hs          = mpu_trans_valid_o && mpu_trans_ready_i;
  // An XIF request the MPU rejects never gets a response, so it is not tracked.
  assign w_push        = w_hs && !(w_sel_xif && mpu_err_i);
  assign xif_mpu_err_o = w_hs && w_sel_xif && mpu_err_i;

  // Response routing from the FIFO head; data goes to both ports, only valid is gated.
  assign w_head_xif       = r_owner[r_rptr];
  assign w_pop            = mpu_resp_valid_i && !w_empty;
  assign lsu_resp_valid_o = w_pop && !w_head_xif;
  assign xif_resp_valid_o = w_pop &&  w_head_xif;
  assign lsu_resp_o       = mpu_resp_i;
  assign xif_resp_o       = mpu_resp_i;

  assign w_cnt_nxt            = r_cnt + CntW'(w_push) - CntW'(w_pop);
  assign mpu_one_txn_pend_n_o = (w_cnt_nxt == CntW'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StFree: begin
        if (w_sel_valid && !mpu_trans_ready_i) begin
          w_state_nxt = w_sel_xif ? StHoldXif : StHoldLsu;
        end
      end
      StHoldLsu, StHoldXif: begin
        if (w_hs) w_state_nxt = StFree;
      end
      default: w_state_nxt = StFree;
    endcase
  end

  // XIF loses a cycle whenever it is valid in FREE and the LSU is selected.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_hs && w_sel_xif) begin
      w_starve_nxt = '0;
    end else if ((r_state == StFree) && xif_trans_valid_i && !w_sel_xif &&
                 (r_starve != StvW'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + StvW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StFree;
      r_cnt    <= '0;
      r_starve <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
      if (w_push) begin
        r_owner[r_wptr] <= w_sel_xif;
        r_wptr          <= (r_wptr == PtrW'(DEPTH - 1)) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(DEPTH - 1)) ? '0 : r_rptr + PtrW'(1);
      end
    end
  end

  // Illegal traffic: response with nothing outstanding, push into a full FIFO.
  a_resp_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                     mpu_resp_valid_i |-> !w_empty);
  a_push_not_full:  assert property (@(posedge clk) disable iff (!rst_n)
                                     w_push |-> !w_full);

endmodule

// File: tb/tb_cv32e40x_mpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cv32e40x_mpu_arbiter
//
// Directed per-cycle vectors for the MPU arbiter (DEPTH=2, STARVE_LIMIT=4).
// Each row holds the inputs for one cycle and the expected combinational
// outputs for that cycle. Rows run back to back, so state carries over.
// -----------------------------------------------------------------------------
module tb_cv32e40x_mpu_arbiter;

  localparam logic [31:0] LT = 32'h1111_aaaa;
  localparam logic [31:0] XT = 32'h2222_bbbb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_trans_valid, lsu_trans_ready, lsu_resp_valid;
  logic        xif_trans_valid, xif_trans_ready, xif_resp_valid, xif_mpu_err;
  logic        mpu_trans_valid, mpu_trans_ready, mpu_err_wait, mpu_err;
  logic        mpu_one_txn_pend_n, mpu_resp_valid;
  logic [31:0] lsu_trans, xif_trans, mpu_trans, lsu_resp, xif_resp, mpu_resp;

  always #5 clk = ~clk;

  cv32e40x_mpu_arbiter #(
    .TRANS_TYPE  (logic [31:0]),
    .RESP_TYPE   (logic [31:0]),
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_trans_valid_i   (lsu_trans_valid),
    .lsu_trans_ready_o   (lsu_trans_ready),
    .lsu_trans_i         (lsu_trans),
    .lsu_resp_valid_o    (lsu_resp_valid),
    .lsu_resp_o          (lsu_resp),
    .xif_trans_valid_i   (xif_trans_valid),
    .xif_trans_ready_o   (xif_trans_ready),
    .xif_trans_i         (xif_trans),
    .xif_resp_valid_o    (xif_resp_valid),
    .xif_resp_o          (xif_resp),
    .xif_mpu_err_o       (xif_mpu_err),
    .mpu_trans_valid_o   (mpu_trans_valid),
    .mpu_trans_ready_i   (mpu_trans_ready),
    .mpu_trans_o         (mpu_trans),
    .mpu_err_wait_o      (mpu_err_wait),
    .mpu_err_i           (mpu_err),
    .mpu_one_txn_pend_n_o(mpu_one_txn_pend_n),
    .mpu_resp_valid_i    (mpu_resp_valid),
    .mpu_resp_i          (mpu_resp)
  );

  // in  : {lsu_valid, xif_valid, mpu_ready, mpu_err, mpu_resp_valid}
  // exp : {lsu_ready, xif_ready, mpu_valid, err_wait, xif_mpu_err,
  //        lsu_resp_valid, xif_resp_valid, one_txn_pend_n}
  // selx: 1 when mpu_trans_o must carry the XIF request
  typedef struct {
    logic [4:0] in;
    logic [7:0] exp;
    logic       selx;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_out(input string tag, input logic [7:0] ef, input logic selx,
                           input logic [31:0] rd);
    logic [7:0]  af;
    logic [31:0] et;
    af = {lsu_trans_ready, xif_trans_ready, mpu_trans_valid, mpu_err_wait, xif_mpu_err,
          lsu_resp_valid, xif_resp_valid, mpu_one_txn_pend_n};
    et = selx ? XT : LT;
    n_cmp++;
    if (af !== ef) begin
      n_err++;
      $display("FAIL %s flags: got %b expected %b", tag, af, ef);
    end
    n_cmp++;
    if (mpu_trans !== et) begin
      n_err++;
      $display("FAIL %s mpu_trans: got %h expected %h", tag, mpu_trans, et);
    end
    n_cmp++;
    if ({lsu_resp, xif_resp} !== {rd, rd}) begin
      n_err++;
      $display("FAIL %s resp data: got %h/%h expected %h", tag, lsu_resp, xif_resp, rd);
    end
  endtask

  // Drive one cycle just after the rising edge, check on the falling edge.
  task automatic apply(input vec_t v, input string tag, input int k);
    logic [31:0] rd;
    rd = 32'hc0de_0000 | 32'(k);
    {lsu_trans_valid, xif_trans_valid, mpu_trans_ready, mpu_err, mpu_resp_valid} = v.in;
    mpu_resp = rd;
    @(negedge clk);
    check_out(tag, v.exp, v.selx, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_trans = LT;
    xif_trans = XT;
    {lsu_trans_valid, xif_trans_valid, mpu_trans_ready, mpu_err, mpu_resp_valid} = '0;
    mpu_resp = 32'hc0de_0000;

    // Starvation: LSU wins 4 cycles, XIF the 5th, responses one cycle later
    vecs.push_back('{5'b11100, 8'b1011_0001, 1'b0});
    vecs.push_back('{5'b11101, 8'b1011_0101, 1'b0});
    vecs.push_back('{5'b11101, 8'b1011_0101, 1'b0});
    vecs.push_back('{5'b11101, 8'b1011_0101, 1'b0});
    vecs.push_back('{5'b11101, 8'b0110_0101, 1'b1});
    vecs.push_back('{5'b11101, 8'b1011_0011, 1'b0});
    vecs.push_back('{5'b00001, 8'b0001_0100, 1'b0});
    // LSU held 3 cycles with XIF arriving, then accepted
    vecs.push_back('{5'b10000, 8'b0011_0000, 1'b0});
    vecs.push_back('{5'b11000, 8'b0011_0000, 1'b0});
    vecs.push_back('{5'b11000, 8'b0011_0000, 1'b0});
    vecs.push_back('{5'b11100, 8'b1011_0001, 1'b0});
    // XIF held while LSU arrives: selection must not flip to LSU
    vecs.push_back('{5'b01001, 8'b0010_0100, 1'b1});
    vecs.push_back('{5'b11000, 8'b0010_0000, 1'b1});
    vecs.push_back('{5'b11100, 8'b0110_0001, 1'b1});
    vecs.push_back('{5'b10101, 8'b1011_0011, 1'b0});
    // Fill to DEPTH: third request stalls until first response; order L,X,L
    vecs.push_back('{5'b01100, 8'b0110_0000, 1'b1});
    vecs.push_back('{5'b10100, 8'b0001_0000, 1'b0});
    vecs.push_back('{5'b10101, 8'b0001_0101, 1'b0});
    vecs.push_back('{5'b10101, 8'b1011_0011, 1'b0});
    vecs.push_back('{5'b00001, 8'b0001_0100, 1'b0});
    // XIF immediate error: pulse, no push
    vecs.push_back('{5'b01110, 8'b0110_1000, 1'b1});
    vecs.push_back('{5'b00000, 8'b0001_0000, 1'b0});
    // LSU immediate error: pushed, response later routed to LSU
    vecs.push_back('{5'b10110, 8'b1011_0001, 1'b0});
    vecs.push_back('{5'b00001, 8'b0001_0100, 1'b0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", 8'b0001_0000, 1'b0, 32'hc0de_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i), i);

    // Reset mid-operation with cnt=2 and the grant held on XIF
    apply('{5'b10100, 8'b1011_0001, 1'b0}, "rst_fill0", 100);
    apply('{5'b01100, 8'b0110_0000, 1'b1}, "rst_fill1", 101);
    apply('{5'b01000, 8'b0000_0000, 1'b1}, "rst_holdx0", 102);
    apply('{5'b11000, 8'b0000_0000, 1'b1}, "rst_holdx1", 103);
    rst_n = 1'b0;
    {lsu_trans_valid, xif_trans_valid, mpu_trans_ready, mpu_err, mpu_resp_valid} = '0;
    mpu_resp = 32'hc0de_0068;
    #1;
    check_out("rst_async", 8'b0001_0000, 1'b0, 32'hc0de_0068);
    @(posedge clk);
    #1;
    check_out("rst_next", 8'b0001_0000, 1'b0, 32'hc0de_0068);
    rst_n = 1'b1;
    // FIFO empty after reset: a single push leaves exactly one outstanding
    apply('{5'b10100, 8'b1011_0001, 1'b0}, "post_rst0", 104);
    apply('{5'b00001, 8'b0001_0100, 1'b0}, "post_rst1", 105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
